// File: rtl/spn_pkg.sv
// rtl/spn_pkg.sv - shared SPN datapath sizes, nibble type and bit permutation
package spn_pkg;

  localparam int SPN_NIB = 4;
  localparam int SPN_W   = 4 * SPN_NIB;

  typedef logic [3:0] nibble_t;

  // Nibble n, bit b lands at output bit b*SPN_NIB + n (nibble/bit transpose).
  function automatic logic [SPN_W-1:0] perm(input logic [SPN_W-1:0] x);
    logic [SPN_W-1:0] y;
    y = '0;
    for (int n = 0; n < SPN_NIB; n++) begin
      for (int b = 0; b < 4; b++) begin
        y[b*SPN_NIB + n] = x[4*n + b];
      end
    end
    return y;
  endfunction

endpackage

// File: rtl/spn_perm.sv
// rtl/spn_perm.sv - combinational SPN bit permutation, pure wiring
module spn_perm
  import spn_pkg::*;
#(
  parameter int NIB = SPN_NIB
) (
  input  logic [4*NIB-1:0] din,
  output logic [4*NIB-1:0] dout
);

  for (genvar n = 0; n < NIB; n++) begin : g_nib
    for (genvar b = 0; b < 4; b++) begin : g_bit
      assign dout[b*NIB + n] = din[4*n + b];
    end
  end

endmodule

// File: rtl/sbox_perm_collect.sv
// rtl/sbox_perm_collect.sv - assembles S-box nibbles into permuted blocks behind a one-entry buffer
module sbox_perm_collect
  import spn_pkg::*;
#(
  parameter int NIB = SPN_NIB,
  parameter int CW  = 8
) (
  input  logic             ck,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_nib,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [4*NIB-1:0] out_data,
  output logic [CW-1:0]    blk_cnt,
  output logic             busy
);

  localparam int W    = 4 * NIB;
  localparam int CNTW = $clog2(NIB);

  logic [CNTW-1:0] cnt;
  logic [W-1:0]    acc;
  logic [W-1:0]    acc_next;
  logic [W-1:0]    permuted;
  nibble_t         nib;
  logic            at_last;
  logic            accept;
  logic            finish;
  logic            handoff;

  assign nib      = in_nib;
  assign at_last  = (cnt == CNTW'(NIB - 1));
  // Only the final nibble needs the buffer free; earlier ones overlap a full buffer.
  assign in_ready = !at_last || !out_valid || out_ready;
  assign accept   = in_valid && in_ready && !clr;
  assign finish   = accept && at_last;
  assign handoff  = out_valid && out_ready;
  assign busy     = (cnt != '0);

  assign acc_next = acc | (W'(nib) << {cnt, 2'b00});

  spn_perm #(.NIB(NIB)) u_perm (
    .din  (acc_next),
    .dout (permuted)
  );

  always_ff @(posedge ck) begin
    if (!rst_n) begin
      cnt       <= '0;
      acc       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      blk_cnt   <= '0;
    end else begin
      if (clr) begin
        cnt <= '0;
        acc <= '0;
      end else if (accept) begin
        if (at_last) begin
          cnt <= '0;
          acc <= '0;
        end else begin
          cnt <= cnt + CNTW'(1);
          acc <= acc_next;
        end
      end

      // A landing block overrides the drop so back-to-back blocks have no bubble.
      if (finish) begin
        out_valid <= 1'b1;
        out_data  <= permuted;
      end else if (handoff) begin
        out_valid <= 1'b0;
      end

      if (handoff) begin
        blk_cnt <= blk_cnt + CW'(1);
      end
    end
  end

endmodule

// File: doc/sbox_perm_collect.md
Name: sbox_perm_collect

Overview:
- Downstream neighbour of the 4-bit S-box stage in the toy SPN datapath.
- Collects one registered 4-bit S-box output per accepted beat and assembles NIB nibbles into a 4*NIB-bit block.
- Applies the fixed SPN bit permutation (nibble/bit transpose) and presents the permuted block through a one-entry valid/ready output buffer to the key-mix/next-round stage.

Parameters:
- NIB, 4, nibbles per block; block width W = 4*NIB; legal range 2..16.
- CW, 8, width of the emitted-block counter blk_cnt.

Ports:
- ck  input  1  clock; all state updates on posedge ck.
- rst_n  input  1  reset; synchronous, active-low.
- clr  input  1  synchronous abort of the partial block being assembled; the output buffer is untouched.
- in_valid  input  1  in_nib is valid this cycle.
- in_ready  output  1  block accepts in_nib this cycle.
- in_nib  input  4  S-box output nibble.
- out_valid  output  1  out_data holds a permuted block.
- out_ready  input  1  consumer takes out_data this cycle.
- out_data  output  W  permuted block.
- blk_cnt  output  CW  count of blocks handed off on the output handshake; wraps modulo 2^CW.
- busy  output  1  partial block in progress (nibble count != 0).

Behaviour:
- Reset (rst_n=0 at posedge ck): nib count=0, accumulator=0, out_valid=0, out_data=0, blk_cnt=0, busy=0. Reset has priority over every other input.
- in_ready = (cnt != NIB-1) || !out_valid || out_ready. in_ready is combinational and carries no dependency on in_valid.
- Accept = in_valid && in_ready && !clr.
- Nibble placement: the k-th accepted nibble of a block (k=0 first) is written to accumulator bits [4k+3:4k]. cnt then increments.
- Final nibble (accept with cnt==NIB-1):
  - next cycle: out_data = perm(assembled block incl. this nibble), out_valid=1, cnt=0, accumulator cleared.
  - Latency: 1 cycle from the final-nibble accept to out_valid.
- Permutation: input bit index 4n+b (nibble n, bit b) maps to output bit index b*NIB+n. It is a bijection on W bits and an involution for NIB=4.
- Output handshake: out_valid && out_ready completes the transfer. blk_cnt increments, wrapping (2^CW-1) to 0. If no new block lands that cycle, out_valid drops to 0 next cycle.
- Simultaneous final-nibble accept and output handshake: the new block replaces the old one with out_valid held at 1 (no bubble). blk_cnt increments once.
- Buffer full with partial block: nibbles 0..NIB-2 are still accepted (overlap). Only the final nibble stalls, via in_ready=0.
- out_data and out_valid hold stable while out_valid=1 and out_ready=0.
- clr:
  - cnt=0 and accumulator=0 next cycle.
  - The nibble presented in the same cycle is discarded.
  - out_valid, out_data and blk_cnt are unaffected; an output handshake in the same cycle still completes.
- Stall handling: the S-box stage has no stall. The issuing controller sees in_ready and accounts for the S-box's one-cycle latency; this block never drops an accepted nibble.
- busy = (cnt != 0).

Decomposition:
- Shared package spn_pkg:
  - NIB default, W
  - function perm(W-bit) implementing the index map
  - nibble typedef (4-bit)
- This package is shared with the key-mix and round-control blocks.
- One combinational sub-module, spn_perm (W-bit in, W-bit out, pure wiring), so the same permutation is reused by the round controller and its bench model.
- Counter, accumulator and output buffer stay in sbox_perm_collect.

Test Plan:
- Reset then basic: rst_n low 2 cycles, then nibbles 0x1,0x2,0x3,0x4 on consecutive cycles with out_ready=1 -> out_valid=1 one cycle after the 4th nibble, out_data=0x0865, blk_cnt=1 after the handshake cycle.
- Single-bit routing: nibbles 0x8,0x0,0x0,0x0 -> out_data=0x1000. All 0xF -> 0xFFFF. All 0x0 -> 0x0000.
- Backpressure overlap: out_ready=0, stream 8 nibbles continuously ->
  - block A held stable.
  - nibbles 5..7 accepted; in_ready=0 while the 8th is presented.
  - Raising out_ready: A transferred, 8th nibble accepted the same cycle, B valid next cycle with no gap.
- clr mid-block: 2 nibbles, then clr with in_valid=1 and nibble 0xF, then 4 nibbles 0x1,0x2,0x3,0x4 -> busy=0 after clr, out_data=0x0865. Partial data and the clr-cycle nibble never appear.
- Wrap and reset mid-operation:
  - 256 blocks -> blk_cnt returns to 0.
  - Then rst_n low with out_valid=1 and cnt=2 -> next cycle out_valid=0, busy=0, blk_cnt=0, in_ready=1.
- Random: random in_valid/out_ready over 10k cycles against a spn_perm reference model -> no lost, duplicated or reordered blocks; out_data stable while stalled.
